// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads a 1-cycle imem and buffers {pc, instr} for a valid/ready consumer.
// First instr_valid three edges after reset release; issue is credit-limited so responses always fit.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  misalign_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  req_epoch_q, req_epoch_d;
  logic                  epoch_q, epoch_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0] dat_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q  [FIFO_DEPTH];

  logic          run;
  logic          fire;
  logic          push;
  logic          issue;
  logic [OW-1:0] occ;
  logic [OW-1:0] lim;

  assign run         = (state_q == S_RUN);
  assign instr_valid = run && (count_q != '0);
  assign fire        = instr_valid && instr_ready;
  // A redirect at the response edge flushes, so the response is never written.
  assign push        = run && inflight_q && (req_epoch_q == epoch_q) && !redirect;

  // Credit: buffered + in-flight entries (less the one leaving) must leave room.
  assign occ   = OW'(count_q) + OW'(inflight_q);
  assign lim   = OW'(FIFO_DEPTH) + OW'(fire);
  assign issue = run && !redirect && (occ < lim);

  assign imem_req     = issue;
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
  assign instr        = instr_valid ? dat_mem_q[rd_ptr_q] : '0;
  assign instr_pc     = instr_valid ? pc_mem_q[rd_ptr_q]  : '0;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = issue;
    req_epoch_d = req_epoch_q;
    epoch_d     = epoch_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    misalign_d  = misalign_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (redirect) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          if (redirect_target[1:0] != 2'b00) begin
            state_d    = S_HALT;
            misalign_d = 1'b1;
          end else begin
            pc_d    = redirect_target;
            epoch_d = ~epoch_q;
          end
        end else begin
          if (issue) begin
            pc_d        = pc_q + ADDR_WIDTH'(4);
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
          end
          if (push) wr_ptr_d = wr_ptr_q + PW'(1);
          if (fire) rd_ptr_d = rd_ptr_q + PW'(1);
          count_d = count_q + CW'(push) - CW'(fire);
        end
      end
      default: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      req_epoch_q <= req_epoch_d;
      epoch_q     <= epoch_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      misalign_q  <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      dat_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]  <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem returns addr|0x13; expected pcs are queued per scenario and popped on fire.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_target(redirect_target),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr | 32'h13;
  end

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
      end
      if (k < 3) begin
        n_tests++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid k=%0d: got %b want 0", k, instr_valid); end
      end else begin
        n_tests++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d: got %b want 1", k, instr_valid); end
        if (instr_valid && instr_ready) begin
          e = pop_exp();
          n_tests++;
          if (instr_pc !== e || instr !== (e | 32'h13)) begin
            n_fail++; $display("FAIL stream_data k=%0d: got pc=%h instr=%h want pc=%h", k, instr_pc, instr, e);
          end
        end
      end
    end
    instr_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      instr_ready = (k >= 8);
      #1;
      if (k >= 3 && k <= 7) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h13) begin
          n_fail++; $display("FAIL bp_frozen k=%0d: got v=%b pc=%h instr=%h want v=1 pc=0 instr=13", k, instr_valid, instr_pc, instr);
        end
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low k=%0d: got %b want 0", k, imem_req); end
      end
      if (k >= 8 && instr_valid && instr_ready) begin
        e = pop_exp();
        n_tests++;
        if (instr_pc !== e || instr !== (e | 32'h13)) begin
          n_fail++; $display("FAIL bp_data k=%0d: got pc=%h instr=%h want pc=%h", k, instr_pc, instr, e);
        end
      end
    end
    instr_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_left: got %0d pending want 0", exp_q.size()); end
  endtask

  // Redirect at k=4 while req 0x8 is in flight; fire_at_redirect chooses whether head pc 0x4 is consumed.
  task automatic test_redirect(input logic fire_at_redirect, input logic [31:0] tgt);
    logic [31:0] e;
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    if (fire_at_redirect) exp_q.push_back(32'h4);
    for (int i = 0; i < 4; i++) exp_q.push_back(tgt + 32'(i * 4));
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      redirect        = (k == 4);
      redirect_target = tgt;
      instr_ready     = (k != 4) || fire_at_redirect;
      #1;
      if (k == 4) begin
        n_tests++;
        if (imem_req !== 1'b0 || instr_pc !== 32'h4) begin
          n_fail++; $display("FAIL redir_cycle: got req=%b pc=%h want req=0 pc=4", imem_req, instr_pc);
        end
      end
      if (k == 5) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== tgt) begin
          n_fail++; $display("FAIL redir_target_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, tgt);
        end
      end
      if (k == 5 || k == 6) begin
        n_tests++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush k=%0d: got valid=%b want 0", k, instr_valid); end
      end
      if (k == 7) begin
        n_tests++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_latency: got valid=%b want 1", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        e = pop_exp();
        n_tests++;
        if (instr_pc !== e || instr !== (e | 32'h13)) begin
          n_fail++; $display("FAIL redir_data k=%0d: got pc=%h instr=%h want pc=%h", k, instr_pc, instr, e);
        end
      end
    end
    instr_ready = 1'b0;
    redirect = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      redirect        = (k == 4);
      redirect_target = 32'h102;
      #1;
      if (k == 4) begin
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_redir_req: got %b want 0", imem_req); end
      end
      if (k >= 5) begin
        n_tests++;
        if (misalign_err !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
          n_fail++; $display("FAIL mis_halt k=%0d: got err=%b v=%b req=%b want 1 0 0", k, misalign_err, instr_valid, imem_req);
        end
      end else if (instr_valid && instr_ready) begin
        e = pop_exp();
        n_tests++;
        if (instr_pc !== e) begin n_fail++; $display("FAIL mis_data k=%0d: got pc=%h want %h", k, instr_pc, e); end
      end
    end
    redirect = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mis_left: got %0d pending want 0", exp_q.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    do_reset();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req=%b addr=%h v=%b instr=%h pc=%h err=%b want all 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err);
    end
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      if (k == 3) begin
        n_tests++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL midreset_restart: got valid=%b want 1", instr_valid); end
      end
      if (instr_valid && instr_ready) begin
        e = pop_exp();
        n_tests++;
        if (instr_pc !== e) begin n_fail++; $display("FAIL midreset_data k=%0d: got pc=%h want %h", k, instr_pc, e); end
      end
    end
    instr_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_left: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect(1'b0, 32'h100);
    test_redirect(1'b1, 32'h40);
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
